// File: rtl/vlb_mem_arb_pkg.sv
// Shared types for the walker memory-port arbiter.
// Tags carry the source walker in their MSB.
package vlb_mem_arb_pkg;

   localparam int VLB_IDX_W  = 5;
   localparam int VLB_MCN_W  = 58;
   localparam int VLB_DATA_W = 512;

   localparam logic SRC_ILB = 1'b0;
   localparam logic SRC_DLB = 1'b1;

   typedef struct packed {
      logic [VLB_IDX_W:0]   idx;
      logic [VLB_MCN_W-1:0] mcn;
   } mem_req_t;

   typedef struct packed {
      logic [VLB_IDX_W:0]    idx;
      logic [VLB_DATA_W-1:0] data;
   } mem_res_t;

endpackage

// File: rtl/vlb_mem_arb_slot.sv
// One-entry valid/ready register with a typed payload.
// Accepts a new entry whenever empty or being drained.
module vlb_mem_arb_slot
   import vlb_mem_arb_pkg::*;
#(
   parameter type T = mem_req_t
) (
   input  logic clock,
   input  logic reset,
   input  logic i_valid,
   output logic o_ready,
   input  T     i_data,
   output logic o_valid,
   input  logic i_ready,
   output T     o_data
);

   logic r_v;
   T     r_data;

   assign o_ready = ~r_v | i_ready;
   assign o_valid = r_v;
   assign o_data  = r_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_v <= 1'b0;
      end else if (o_ready) begin
         r_v <= i_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (o_ready & i_valid) begin
         r_data <= i_data;
      end
   end

endmodule

// File: rtl/vlb_mem_arb.sv
// Round-robin share of the walker memory port between ilb and dlb walkers.
// Outstanding counters throttle each walker and drive busy_o.
module vlb_mem_arb
   import vlb_mem_arb_pkg::*;
#(
   parameter int IDX_W   = VLB_IDX_W,
   parameter int MCN_W   = VLB_MCN_W,
   parameter int DATA_W  = VLB_DATA_W,
   parameter int MAX_OUT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_i_0_valid,
   output logic              req_i_0_ready,
   input  logic [IDX_W-1:0]  req_i_0_bits_idx,
   input  logic [MCN_W-1:0]  req_i_0_bits_mcn,
   input  logic              req_i_1_valid,
   output logic              req_i_1_ready,
   input  logic [IDX_W-1:0]  req_i_1_bits_idx,
   input  logic [MCN_W-1:0]  req_i_1_bits_mcn,
   output logic              res_o_0_valid,
   input  logic              res_o_0_ready,
   output logic [IDX_W-1:0]  res_o_0_bits_idx,
   output logic [DATA_W-1:0] res_o_0_bits_data,
   output logic              res_o_1_valid,
   input  logic              res_o_1_ready,
   output logic [IDX_W-1:0]  res_o_1_bits_idx,
   output logic [DATA_W-1:0] res_o_1_bits_data,
   output logic              mem_req_o_valid,
   input  logic              mem_req_o_ready,
   output logic [IDX_W:0]    mem_req_o_bits_idx,
   output logic [MCN_W-1:0]  mem_req_o_bits_mcn,
   input  logic              mem_res_i_valid,
   output logic              mem_res_i_ready,
   input  logic [IDX_W:0]    mem_res_i_bits_idx,
   input  logic [DATA_W-1:0] mem_res_i_bits_data,
   output logic              busy_o,
   output logic              err_o
);

   localparam int CW = $clog2(MAX_OUT + 1);

   logic [CW-1:0] r_cnt0, r_cnt1;
   logic          r_last, r_err;

   logic          w_elig0, w_elig1, w_gnt0, w_gnt1;
   logic          w_load, w_acc0, w_acc1;
   logic          w_slot_v, w_rsp_v, w_rsp_rdy, w_sel, w_sel_rdy;
   logic          w_dec0, w_dec1, w_zero0, w_zero1;
   logic [CW-1:0] w_cnt0_nxt, w_cnt1_nxt;
   mem_req_t      w_req_in, w_req_out;
   mem_res_t      w_res_in, w_res_out;

   assign w_elig0 = req_i_0_valid & (r_cnt0 != CW'(MAX_OUT));
   assign w_elig1 = req_i_1_valid & (r_cnt1 != CW'(MAX_OUT));
   // r_last names the previous winner; on a tie the other source goes
   assign w_gnt0  = w_elig0 & (~w_elig1 | (r_last == SRC_DLB));
   assign w_gnt1  = w_elig1 & (~w_elig0 | (r_last == SRC_ILB));

   assign req_i_0_ready = w_load & w_gnt0 & ~reset;
   assign req_i_1_ready = w_load & w_gnt1 & ~reset;
   assign w_acc0 = req_i_0_valid & req_i_0_ready;
   assign w_acc1 = req_i_1_valid & req_i_1_ready;

   always_comb begin
      w_req_in.idx = {SRC_ILB, req_i_0_bits_idx};
      w_req_in.mcn = req_i_0_bits_mcn;
      if (w_gnt1) begin
         w_req_in.idx = {SRC_DLB, req_i_1_bits_idx};
         w_req_in.mcn = req_i_1_bits_mcn;
      end
   end

   vlb_mem_arb_slot #(.T(mem_req_t)) u_req_slot (
      .clock   (clock),
      .reset   (reset),
      .i_valid ((w_elig0 | w_elig1) & ~reset),
      .o_ready (w_load),
      .i_data  (w_req_in),
      .o_valid (w_slot_v),
      .i_ready (mem_req_o_ready),
      .o_data  (w_req_out)
   );

   assign mem_req_o_valid    = w_slot_v & ~reset;
   assign mem_req_o_bits_idx = w_req_out.idx;
   assign mem_req_o_bits_mcn = w_req_out.mcn;

   assign w_res_in.idx  = mem_res_i_bits_idx;
   assign w_res_in.data = mem_res_i_bits_data;
   assign w_sel     = (w_res_out.idx[IDX_W] == SRC_DLB);
   assign w_sel_rdy = w_sel ? res_o_1_ready : res_o_0_ready;

   vlb_mem_arb_slot #(.T(mem_res_t)) u_rsp_slot (
      .clock   (clock),
      .reset   (reset),
      .i_valid (mem_res_i_valid & ~reset),
      .o_ready (w_rsp_rdy),
      .i_data  (w_res_in),
      .o_valid (w_rsp_v),
      .i_ready (w_sel_rdy),
      .o_data  (w_res_out)
   );

   assign mem_res_i_ready   = w_rsp_rdy & ~reset;
   assign res_o_0_valid     = w_rsp_v & ~w_sel & ~reset;
   assign res_o_1_valid     = w_rsp_v & w_sel & ~reset;
   assign res_o_0_bits_idx  = w_res_out.idx[IDX_W-1:0];
   assign res_o_1_bits_idx  = w_res_out.idx[IDX_W-1:0];
   assign res_o_0_bits_data = w_res_out.data;
   assign res_o_1_bits_data = w_res_out.data;

   assign w_dec0  = res_o_0_valid & res_o_0_ready;
   assign w_dec1  = res_o_1_valid & res_o_1_ready;
   assign w_zero0 = (r_cnt0 == '0);
   assign w_zero1 = (r_cnt1 == '0);
   // a return with nothing outstanding must not wrap the counter
   assign w_cnt0_nxt = r_cnt0 + CW'(w_acc0) - CW'(w_dec0 & ~w_zero0);
   assign w_cnt1_nxt = r_cnt1 + CW'(w_acc1) - CW'(w_dec1 & ~w_zero1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
         r_last <= SRC_DLB;
         r_err  <= 1'b0;
      end else begin
         r_cnt0 <= w_cnt0_nxt;
         r_cnt1 <= w_cnt1_nxt;
         if (w_acc0 | w_acc1) begin
            r_last <= w_acc1;
         end
         if ((w_dec0 & w_zero0) | (w_dec1 & w_zero1)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign busy_o = (w_slot_v | w_rsp_v | ~w_zero0 | ~w_zero1) & ~reset;
   assign err_o  = r_err & ~reset;

endmodule

// File: tb/tb_vlb_mem_arb.sv
// Bench for vlb_mem_arb: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model.
module tb_vlb_mem_arb;
   import vlb_mem_arb_pkg::*;

   localparam int MAXO = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         q0_v, q0_r, q1_v, q1_r;
   logic [4:0]   q0_idx, q1_idx;
   logic [57:0]  q0_mcn, q1_mcn;
   logic         s0_v, s0_r, s1_v, s1_r;
   logic [4:0]   s0_idx, s1_idx;
   logic [511:0] s0_d, s1_d;
   logic         m_v, m_r;
   logic [5:0]   m_idx;
   logic [57:0]  m_mcn;
   logic         r_v, r_r;
   logic [5:0]   r_idx;
   logic [511:0] r_d;
   logic         busy, err;

   always #5 clock = ~clock;

   vlb_mem_arb #(.MAX_OUT(MAXO)) dut (
      .clock               (clock),
      .reset               (reset),
      .req_i_0_valid       (q0_v),
      .req_i_0_ready       (q0_r),
      .req_i_0_bits_idx    (q0_idx),
      .req_i_0_bits_mcn    (q0_mcn),
      .req_i_1_valid       (q1_v),
      .req_i_1_ready       (q1_r),
      .req_i_1_bits_idx    (q1_idx),
      .req_i_1_bits_mcn    (q1_mcn),
      .res_o_0_valid       (s0_v),
      .res_o_0_ready       (s0_r),
      .res_o_0_bits_idx    (s0_idx),
      .res_o_0_bits_data   (s0_d),
      .res_o_1_valid       (s1_v),
      .res_o_1_ready       (s1_r),
      .res_o_1_bits_idx    (s1_idx),
      .res_o_1_bits_data   (s1_d),
      .mem_req_o_valid     (m_v),
      .mem_req_o_ready     (m_r),
      .mem_req_o_bits_idx  (m_idx),
      .mem_req_o_bits_mcn  (m_mcn),
      .mem_res_i_valid     (r_v),
      .mem_res_i_ready     (r_r),
      .mem_res_i_bits_idx  (r_idx),
      .mem_res_i_bits_data (r_d),
      .busy_o              (busy),
      .err_o               (err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
   endtask

   function automatic logic [511:0] rand_data();
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      return d;
   endfunction

   // ---------------- behavioural model ----------------
   int       cnt [2];
   mem_req_t sq[$];
   mem_res_t rq[$];
   bit       last_src;
   bit       merr;

   always @(negedge clock) begin : cmp
      bit ld, el0, el1, win, er0, er1, sel, ev0, ev1, mrr;
      bit hs0, hs1, hr0, hr1;
      logic [511:0] ed;
      if (reset) begin
         chk("rst_mreq_v", m_v, 0);
         chk("rst_res0_v", s0_v, 0);
         chk("rst_res1_v", s1_v, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err", err, 0);
         cnt[0] = 0;
         cnt[1] = 0;
         sq.delete();
         rq.delete();
         last_src = 1;
         merr = 0;
      end else begin
         ld  = (sq.size() == 0) || m_r;
         el0 = q0_v && (cnt[0] < MAXO);
         el1 = q1_v && (cnt[1] < MAXO);
         win = (el0 && el1) ? !last_src : el1;
         er0 = ld && el0 && (win == 0);
         er1 = ld && el1 && (win == 1);
         sel = (rq.size() != 0) ? rq[0].idx[5] : 1'b0;
         ev0 = (rq.size() != 0) && !sel;
         ev1 = (rq.size() != 0) && sel;
         mrr = (rq.size() == 0) || (sel ? s1_r : s0_r);

         chk("mreq_v", m_v, sq.size() != 0);
         if (sq.size() != 0) begin
            chk("mreq_idx", m_idx, sq[0].idx);
            chk("mreq_mcn", m_mcn, sq[0].mcn);
         end
         chk("req0_rdy", q0_r, er0);
         chk("req1_rdy", q1_r, er1);
         chk("res0_v", s0_v, ev0);
         chk("res1_v", s1_v, ev1);
         if (rq.size() != 0) begin
            ed = rq[0].data;
            for (int k = 0; k < 8; k++) begin
               if (ev0) chk("res0_data", s0_d[k*64 +: 64], ed[k*64 +: 64]);
               else     chk("res1_data", s1_d[k*64 +: 64], ed[k*64 +: 64]);
            end
            if (ev0) chk("res0_idx", s0_idx, rq[0].idx[4:0]);
            else     chk("res1_idx", s1_idx, rq[0].idx[4:0]);
         end
         chk("mres_rdy", r_r, mrr);
         chk("busy", busy,
             (sq.size() != 0) || (rq.size() != 0) || (cnt[0] != 0) || (cnt[1] != 0));
         chk("err", err, merr);

         hs0 = er0;
         hs1 = er1;
         if ((sq.size() != 0) && m_r) void'(sq.pop_front());
         if (hs0 || hs1) begin
            sq.push_back('{idx: {hs1, hs1 ? q1_idx : q0_idx},
                           mcn: hs1 ? q1_mcn : q0_mcn});
            last_src = hs1;
         end
         hr0 = ev0 && s0_r;
         hr1 = ev1 && s1_r;
         if (hr0 || hr1) void'(rq.pop_front());
         if (r_v && mrr) rq.push_back('{idx: r_idx, data: r_d});
         if (hr0 && cnt[0] == 0) merr = 1;
         if (hr1 && cnt[1] == 0) merr = 1;
         cnt[0] = cnt[0] + int'(hs0) - ((hr0 && cnt[0] > 0) ? 1 : 0);
         cnt[1] = cnt[1] + int'(hs1) - ((hr1 && cnt[1] > 0) ? 1 : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      q0_v = 0; q1_v = 0; r_v = 0;
      q0_idx = '0; q1_idx = '0; q0_mcn = '0; q1_mcn = '0;
      r_idx = '0; r_d = '0;
      m_r = 1; s0_r = 1; s1_r = 1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      @(negedge clock);
      chk("rst_busy_d", busy, 0);
      tick();
      reset = 0;
   endtask

   logic [5:0]   tie_tags [4] = '{6'h03, 6'h27, 6'h03, 6'h27};
   logic [511:0] dA, dB;
   logic [5:0]   tags[$];
   bit           r_hs;

   initial begin
      idle();
      do_reset();
      @(negedge clock);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_err", err, 0);
      chk("post_rst_mreq_v", m_v, 0);
      tick();

      // alternating grants on a permanent tie
      q0_v = 1; q0_idx = 5'd3; q0_mcn = 58'h100;
      q1_v = 1; q1_idx = 5'd7; q1_mcn = 58'h200;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("tie_rdy0", q0_r, (i % 2) == 0);
         chk("tie_rdy1", q1_r, (i % 2) == 1);
         if (i > 0) chk("tie_tag", m_idx, tie_tags[i-1]);
         tick();
      end
      q0_v = 0; q1_v = 0;
      @(negedge clock);
      chk("tie_tag", m_idx, tie_tags[3]);
      tick();

      // memory stall holds the slot
      do_reset();
      m_r = 0; q0_v = 1; q0_idx = 5'd1; q0_mcn = 58'h1234;
      @(negedge clock);
      chk("stall_first_acc", q0_r, 1);
      tick();
      q0_mcn = 58'h5678; q1_v = 1; q1_idx = 5'd4; q1_mcn = 58'h9;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stall_v", m_v, 1);
         chk("stall_mcn", m_mcn, 58'h1234);
         chk("stall_idx", m_idx, 6'h01);
         chk("stall_rdy0", q0_r, 0);
         chk("stall_rdy1", q1_r, 0);
         tick();
      end
      m_r = 1;
      @(negedge clock);
      chk("stall_rel_mcn", m_mcn, 58'h1234);
      chk("stall_rel_rdy1", q1_r, 1);
      chk("stall_rel_rdy0", q0_r, 0);
      tick();
      q0_v = 0; q1_v = 0;
      @(negedge clock);
      chk("stall_next_idx", m_idx, 6'h24);
      chk("stall_next_mcn", m_mcn, 58'h9);
      tick();

      // outstanding limit on source 0
      do_reset();
      q0_v = 1;
      for (int i = 0; i < 8; i++) begin
         q0_idx = 5'(i);
         @(negedge clock);
         chk("thr_rdy", q0_r, 1);
         tick();
      end
      q0_idx = 5'd8;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk("thr_block", q0_r, 0);
         chk("thr_busy", busy, 1);
         tick();
      end
      dA = rand_data();
      r_v = 1; r_idx = 6'h00; r_d = dA;
      @(negedge clock);
      chk("thr_mres_rdy", r_r, 1);
      tick();
      r_v = 0;
      @(negedge clock);
      chk("thr_res0_v", s0_v, 1);
      chk("thr_no_early", q0_r, 0);
      tick();
      @(negedge clock);
      chk("thr_reopen", q0_r, 1);
      tick();
      @(negedge clock);
      chk("thr_full_again", q0_r, 0);
      tick();
      q0_v = 0;

      // routing and a stalled target
      do_reset();
      q0_v = 1; q0_idx = 5'd2; q1_v = 1; q1_idx = 5'd5;
      @(negedge clock);
      chk("rt_acc0", q0_r, 1);
      tick();
      @(negedge clock);
      chk("rt_acc1", q1_r, 1);
      tick();
      q0_v = 0; q1_v = 0;
      dA = rand_data(); dB = rand_data();
      s1_r = 0; r_v = 1; r_idx = 6'h25; r_d = dA;
      @(negedge clock);
      chk("rt_mres_rdy", r_r, 1);
      tick();
      r_idx = 6'h02; r_d = dB;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("rt_res1_v", s1_v, 1);
         chk("rt_res1_idx", s1_idx, 5'd5);
         chk("rt_res1_data", s1_d[63:0], dA[63:0]);
         chk("rt_res0_v", s0_v, 0);
         chk("rt_block", r_r, 0);
         tick();
      end
      s1_r = 1;
      @(negedge clock);
      chk("rt_rel_rdy", r_r, 1);
      tick();
      r_v = 0;
      @(negedge clock);
      chk("rt_res0_v", s0_v, 1);
      chk("rt_res0_idx", s0_idx, 5'd2);
      chk("rt_res0_data", s0_d[511:448], dB[511:448]);
      chk("rt_res1_off", s1_v, 0);
      tick();
      @(negedge clock);
      chk("rt_idle_busy", busy, 0);
      chk("rt_err", err, 0);
      tick();

      // response with nothing outstanding
      do_reset();
      r_v = 1; r_idx = 6'h20; r_d = '0;
      @(negedge clock);
      chk("sp_mres_rdy", r_r, 1);
      tick();
      r_v = 0;
      @(negedge clock);
      chk("sp_res1_v", s1_v, 1);
      chk("sp_err_early", err, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("sp_err", err, 1);
         chk("sp_cnt_zero", busy, 0);
         tick();
      end

      // reset with everything in flight
      do_reset();
      s0_r = 0;
      q0_v = 1; q0_idx = 5'd1; q1_v = 1; q1_idx = 5'd2;
      repeat (5) tick();
      q0_v = 0; q1_v = 0; m_r = 0;
      r_v = 1; r_idx = 6'h00;
      @(negedge clock);
      chk("mr_busy", busy, 1);
      tick();
      r_v = 0;
      @(negedge clock);
      chk("mr_res0_v", s0_v, 1);
      chk("mr_mreq_v", m_v, 1);
      tick();
      reset = 1;
      @(negedge clock);
      chk("mr_in_rst_busy", busy, 0);
      tick();
      reset = 0; m_r = 1; s0_r = 1; q0_v = 1; q1_v = 1;
      @(negedge clock);
      chk("mr_busy0", busy, 0);
      chk("mr_mreq_v0", m_v, 0);
      chk("mr_res0_v0", s0_v, 0);
      chk("mr_tie0", q0_r, 1);
      chk("mr_tie1", q1_r, 0);
      tick();
      q0_v = 0; q1_v = 0;

      // randomized traffic
      do_reset();
      r_hs = 0;
      for (int c = 0; c < 4000; c++) begin
         q0_v   = ($urandom_range(0, 2) != 0);
         q1_v   = ($urandom_range(0, 2) != 0);
         q0_idx = 5'($urandom());
         q1_idx = 5'($urandom());
         q0_mcn = 58'({$urandom(), $urandom()});
         q1_mcn = 58'({$urandom(), $urandom()});
         m_r    = ($urandom_range(0, 3) != 0);
         s0_r   = ($urandom_range(0, 3) != 0);
         s1_r   = ($urandom_range(0, 3) != 0);
         if (!r_v || r_hs) begin
            r_v = 0;
            if (tags.size() != 0 && $urandom_range(0, 1) == 1) begin
               int j;
               j = $urandom_range(0, tags.size() - 1);
               r_idx = tags[j];
               tags.delete(j);
               r_d = rand_data();
               r_v = 1;
            end else if ($urandom_range(0, 299) == 0) begin
               r_idx = 6'($urandom());
               r_d = rand_data();
               r_v = 1;
            end
         end
         reset = ($urandom_range(0, 699) == 0);
         @(negedge clock);
         if (m_v && m_r && !reset) tags.push_back(m_idx);
         r_hs = r_v && r_r;
         tick();
      end
      reset = 0;
      idle();
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
